// File: rtl/vqueue_filler.sv
// Video queue filler: fetches fixed-length memory bursts into a write queue, walking a frame buffer.
// Optional frame restart input Vsync is built only when VQUEUE_FILLER_VSYNC_EN is defined.
module vqueue_filler #(
  parameter int addr_width  = 22,
  parameter int burst_len   = 8,
  parameter int frame_words = 24576
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [addr_width-1:0] Base,
  output logic                  MemReq,
  output logic [addr_width-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic                  MemValid,
  input  logic [31:0]           MemData,
  output logic                  QWrEn,
  output logic [31:0]           QData,
  input  logic                  QAlmostEmpty,
  output logic                  FrameStart
`ifdef VQUEUE_FILLER_VSYNC_EN
  ,
  input  logic                  Vsync
`endif
);

  // state  | meaning
  // IDLE   | waiting for Enable and a nearly empty queue
  // REQ    | burst request held until MemAck
  // DATA   | forwarding burst_len read words into the queue
  // SETTLE | two cycles for QAlmostEmpty to reflect the writes

  localparam int OFF_W      = $clog2(frame_words);
  localparam int CNT_W      = $clog2(burst_len);
  localparam int SETTLE_CYC = 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_SETTLE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [OFF_W-1:0]      r_offset;
  logic [OFF_W-1:0]      w_offset_eff;
  logic [OFF_W-1:0]      w_offset_next;
  logic [CNT_W-1:0]      r_word_cnt;
  logic [1:0]            r_settle_cnt;
  logic [addr_width-1:0] r_base;
  logic [addr_width-1:0] r_mem_addr;
  logic [addr_width-1:0] w_base_sel;
  logic                  r_qwren;
  logic [31:0]           r_qdata;
  logic                  r_frame_start;
  logic                  w_vsync_pend;
  logic                  w_start;
  logic                  w_word;
  logic                  w_last;
  logic                  w_frame_first;

`ifdef VQUEUE_FILLER_VSYNC_EN
  logic r_vsync_pend;

  // A pending restart is consumed at the next IDLE, so an in-flight burst always completes.
  always_ff @(posedge Clock) begin
    if (Reset)
      r_vsync_pend <= 1'b0;
    else if (r_state == S_IDLE)
      r_vsync_pend <= 1'b0;
    else if (Vsync)
      r_vsync_pend <= 1'b1;
  end

  assign w_vsync_pend = r_vsync_pend | Vsync;
`else
  assign w_vsync_pend = 1'b0;
`endif

  assign w_offset_eff  = w_vsync_pend ? '0 : r_offset;
  assign w_frame_first = (w_offset_eff == '0);
  assign w_base_sel    = w_frame_first ? Base : r_base;
  assign w_start       = (r_state == S_IDLE) && (w_next == S_REQ);
  assign w_word        = (r_state == S_DATA) && MemValid;
  assign w_last        = w_word && (r_word_cnt == CNT_W'(burst_len - 1));
  assign w_offset_next = (r_offset == OFF_W'(frame_words - burst_len)) ? '0
                                                                       : r_offset + OFF_W'(burst_len);

  always_ff @(posedge Clock) begin
    if (Reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (Enable && QAlmostEmpty) w_next = S_REQ;
      S_REQ:    if (MemAck) w_next = S_DATA;
      S_DATA:   if (w_last) w_next = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == 2'd0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    MemReq     = (r_state == S_REQ);
    MemAddr    = r_mem_addr;
    QWrEn      = r_qwren;
    QData      = r_qdata;
    FrameStart = r_frame_start;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_offset      <= '0;
      r_word_cnt    <= '0;
      r_settle_cnt  <= '0;
      r_base        <= '0;
      r_mem_addr    <= '0;
      r_qwren       <= 1'b0;
      r_qdata       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_qwren       <= w_word;
      r_frame_start <= w_start && w_frame_first;
      if (w_word)
        r_qdata <= MemData;

      // Address and frame base are captured once per request so MemAddr stays put while REQ waits.
      if (w_start) begin
        r_mem_addr <= w_base_sel + addr_width'(w_offset_eff);
        if (w_frame_first)
          r_base <= Base;
      end

      if (w_last)
        r_offset <= w_offset_next;
      else if ((r_state == S_IDLE) && w_vsync_pend)
        r_offset <= '0;

      if (w_last)
        r_word_cnt <= '0;
      else if (w_word)
        r_word_cnt <= r_word_cnt + CNT_W'(1);

      if (w_last)
        r_settle_cnt <= 2'(SETTLE_CYC - 1);
      else if ((r_state == S_SETTLE) && (r_settle_cnt != 2'd0))
        r_settle_cnt <= r_settle_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_vqueue_filler.sv
// Directed bench for vqueue_filler (frame_words=16, burst_len=8); the Vsync scenario builds with VQUEUE_FILLER_VSYNC_EN.
module tb_vqueue_filler;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic [21:0] Base;
  logic        MemReq;
  logic [21:0] MemAddr;
  logic        MemAck;
  logic        MemValid;
  logic [31:0] MemData;
  logic        QWrEn;
  logic [31:0] QData;
  logic        QAlmostEmpty;
  logic        FrameStart;
`ifdef VQUEUE_FILLER_VSYNC_EN
  logic        Vsync;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int qwr_cnt = 0;

  vqueue_filler #(.addr_width(22), .burst_len(8), .frame_words(16)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Base(Base),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemValid(MemValid),
    .MemData(MemData), .QWrEn(QWrEn), .QData(QData), .QAlmostEmpty(QAlmostEmpty),
    .FrameStart(FrameStart)
`ifdef VQUEUE_FILLER_VSYNC_EN
    , .Vsync(Vsync)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) if (QWrEn === 1'b1) qwr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Enable = 1'b0; QAlmostEmpty = 1'b0; MemAck = 1'b0;
    MemValid = 1'b0; MemData = '0; Base = '0;
`ifdef VQUEUE_FILLER_VSYNC_EN
    Vsync = 1'b0;
`endif
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (MemReq === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic ack_once();
    MemAck = 1'b1; step(); MemAck = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] d0, input int gap);
    for (int i = 0; i < n; i++) begin
      MemValid = 1'b1; MemData = d0 + 32'(i); step(); MemValid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (MemReq !== 1'b0) $display("FAIL rst_memreq got=%0h exp=0", MemReq); else n_pass++;
    n_total++; if (QWrEn !== 1'b0) $display("FAIL rst_qwren got=%0h exp=0", QWrEn); else n_pass++;
    n_total++; if (QData !== 32'h0) $display("FAIL rst_qdata got=%h exp=0", QData); else n_pass++;
    n_total++; if (FrameStart !== 1'b0) $display("FAIL rst_framestart got=%0h exp=0", FrameStart); else n_pass++;
    n_total++; if (MemAddr !== 22'h0) $display("FAIL rst_memaddr got=%h exp=0", MemAddr); else n_pass++;
  endtask

  task automatic test_request();
    int req_cnt = 0;
    int fs_cnt  = 0;
    do_reset();
    Base = 22'h1000; Enable = 1'b1; QAlmostEmpty = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (MemReq === 1'b1) req_cnt++;
      if (FrameStart === 1'b1) fs_cnt++;
      n_total++; if (MemAddr !== 22'h1000) $display("FAIL req_addr cycle %0d got=%h exp=001000", c, MemAddr); else n_pass++;
      if (c == 3) MemAck = 1'b1;
    end
    step(); MemAck = 1'b0;
    if (FrameStart === 1'b1) fs_cnt++;
    n_total++; if (MemReq !== 1'b0) $display("FAIL req_drop got=%0h exp=0", MemReq); else n_pass++;
    n_total++; if (req_cnt != 3) $display("FAIL req_cycles got=%0d exp=3", req_cnt); else n_pass++;
    n_total++; if (fs_cnt != 1) $display("FAIL req_framestart_pulses got=%0d exp=1", fs_cnt); else n_pass++;
  endtask

  // Continues from test_request with the DUT in DATA.
  task automatic test_burst();
    int c0 = qwr_cnt;
    for (int i = 0; i < 8; i++) begin
      MemValid = 1'b1; MemData = 32'hA0 + 32'(i);
      step(); MemValid = 1'b0;
      n_total++;
      if ({QWrEn, QData} !== {1'b1, 32'hA0 + 32'(i)})
        $display("FAIL burst_word%0d got we=%0h data=%h exp we=1 data=%h", i, QWrEn, QData, 32'hA0 + 32'(i));
      else n_pass++;
      for (int g = 0; g < ((i < 7) ? (i % 3) : 0); g++) begin
        step();
        n_total++; if (QWrEn !== 1'b0) $display("FAIL burst_gap%0d got=%0h exp=0", i, QWrEn); else n_pass++;
      end
    end
    MemValid = 1'b1; MemData = 32'hEE;
    step(); MemValid = 1'b0;
    n_total++; if (QWrEn !== 1'b0) $display("FAIL settle_ignore got=%0h exp=0", QWrEn); else n_pass++;
    n_total++; if (MemReq !== 1'b0) $display("FAIL settle1_memreq got=%0h exp=0", MemReq); else n_pass++;
    step();
    n_total++; if (MemReq !== 1'b0) $display("FAIL settle2_memreq got=%0h exp=0", MemReq); else n_pass++;
    step();
    n_total++; if (MemReq !== 1'b1) $display("FAIL next_req got=%0h exp=1", MemReq); else n_pass++;
    n_total++; if (MemAddr !== 22'h1008) $display("FAIL next_req_addr got=%h exp=001008", MemAddr); else n_pass++;
    n_total++; if (FrameStart !== 1'b0) $display("FAIL next_req_fs got=%0h exp=0", FrameStart); else n_pass++;
    n_total++; if (qwr_cnt - c0 != 8) $display("FAIL burst_writes got=%0d exp=8", qwr_cnt - c0); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [21:0] exp_addr [3] = '{22'h3FFFFC, 22'h000004, 22'h001000};
    logic        exp_fs   [3] = '{1'b1, 1'b0, 1'b1};
    bit ok;
    do_reset();
    Base = 22'h3FFFFC; Enable = 1'b1; QAlmostEmpty = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_req(ok);
      n_total++; if (!ok) $display("FAIL wrap_wait%0d got=timeout exp=MemReq", b); else n_pass++;
      n_total++; if (MemAddr !== exp_addr[b]) $display("FAIL wrap_addr%0d got=%h exp=%h", b, MemAddr, exp_addr[b]); else n_pass++;
      n_total++; if (FrameStart !== exp_fs[b]) $display("FAIL wrap_fs%0d got=%0h exp=%0h", b, FrameStart, exp_fs[b]); else n_pass++;
      if (b == 0) Base = 22'h001000;
      ack_once();
      send_words(8, 32'(b * 16), 0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c0;
    do_reset();
    Base = 22'h1000; Enable = 1'b1; QAlmostEmpty = 1'b1;
    c0 = qwr_cnt;
    wait_req(ok); ack_once(); send_words(8, 32'hB0, 0);
    wait_req(ok);
    n_total++; if (MemAddr !== 22'h1008) $display("FAIL rmid_addr2 got=%h exp=001008", MemAddr); else n_pass++;
    ack_once(); send_words(4, 32'hC0, 0);
    Reset = 1'b1; QAlmostEmpty = 1'b0; MemValid = 1'b1; MemData = 32'hC4;
    step(); Reset = 1'b0;
    n_total++; if (QWrEn !== 1'b0) $display("FAIL rmid_qwren got=%0h exp=0", QWrEn); else n_pass++;
    n_total++; if (MemReq !== 1'b0) $display("FAIL rmid_memreq got=%0h exp=0", MemReq); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      MemValid = 1'b1; MemData = 32'hC5 + 32'(i); step(); MemValid = 1'b0;
      n_total++; if (QWrEn !== 1'b0) $display("FAIL rmid_late%0d got=%0h exp=0", i, QWrEn); else n_pass++;
    end
    step();
    n_total++; if (qwr_cnt - c0 != 12) $display("FAIL rmid_writes got=%0d exp=12", qwr_cnt - c0); else n_pass++;
    QAlmostEmpty = 1'b1;
    wait_req(ok);
    n_total++; if (!ok) $display("FAIL rmid_wait got=timeout exp=MemReq"); else n_pass++;
    n_total++; if (MemAddr !== 22'h1000) $display("FAIL rmid_addr got=%h exp=001000", MemAddr); else n_pass++;
    n_total++; if (FrameStart !== 1'b1) $display("FAIL rmid_fs got=%0h exp=1", FrameStart); else n_pass++;
  endtask

  task automatic test_enable();
    bit ok;
    int c0;
    int nreq = 0;
    do_reset();
    Base = 22'h2000; Enable = 1'b1; QAlmostEmpty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++; if (MemReq !== 1'b0) $display("FAIL en_notempty%0d got=%0h exp=0", i, MemReq); else n_pass++;
    end
    QAlmostEmpty = 1'b1;
    wait_req(ok);
    n_total++; if (!ok) $display("FAIL en_wait got=timeout exp=MemReq"); else n_pass++;
    ack_once();
    c0 = qwr_cnt;
    send_words(3, 32'hD0, 1);
    Enable = 1'b0;
    send_words(5, 32'hD3, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (MemReq === 1'b1) nreq++;
    end
    n_total++; if (qwr_cnt - c0 != 8) $display("FAIL en_burst_writes got=%0d exp=8", qwr_cnt - c0); else n_pass++;
    n_total++; if (nreq != 0) $display("FAIL en_no_new_req got=%0d exp=0", nreq); else n_pass++;
    Enable = 1'b1;
    wait_req(ok);
    n_total++; if (!ok) $display("FAIL en_resume got=timeout exp=MemReq"); else n_pass++;
    n_total++; if (MemAddr !== 22'h2008) $display("FAIL en_resume_addr got=%h exp=002008", MemAddr); else n_pass++;
    n_total++; if (FrameStart !== 1'b0) $display("FAIL en_resume_fs got=%0h exp=0", FrameStart); else n_pass++;
  endtask

`ifdef VQUEUE_FILLER_VSYNC_EN
  task automatic test_vsync();
    bit ok;
    int c0;
    do_reset();
    Base = 22'h4000; Enable = 1'b1; QAlmostEmpty = 1'b1;
    wait_req(ok);
    n_total++; if (MemAddr !== 22'h4000) $display("FAIL vs_addr1 got=%h exp=004000", MemAddr); else n_pass++;
    ack_once();
    c0 = qwr_cnt;
    send_words(3, 32'hE0, 0);
    Vsync = 1'b1;
    send_words(1, 32'hE3, 0);
    Vsync = 1'b0;
    send_words(4, 32'hE4, 0);
    wait_req(ok);
    n_total++; if (!ok) $display("FAIL vs_wait got=timeout exp=MemReq"); else n_pass++;
    n_total++; if (qwr_cnt - c0 != 8) $display("FAIL vs_burst_writes got=%0d exp=8", qwr_cnt - c0); else n_pass++;
    n_total++; if (MemAddr !== 22'h4000) $display("FAIL vs_restart_addr got=%h exp=004000", MemAddr); else n_pass++;
    n_total++; if (FrameStart !== 1'b1) $display("FAIL vs_restart_fs got=%0h exp=1", FrameStart); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_request();
    test_burst();
    test_wrap();
    test_reset_mid();
    test_enable();
`ifdef VQUEUE_FILLER_VSYNC_EN
    test_vsync();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
